or_bus_arbiter: RTL and testbench
=================================

# or_bus_arbiter

Round-robin arbiter that shares one W-bit OR-combined bus among N requesters. Each requester presents data on its own slice of `din`. Only the granted slice reaches the bus: it is AND-masked with its grant bit and then bitwise OR-reduced. The block sits in front of the shared logic-gate datapath and sequences which source drives it, with an optional per-owner hold limit.

## Interface
- `N`, 4 — number of requesters, 2..16
- `W`, 8 — bus data width, ≥1
- `MAX_HOLD`, 16 — maximum consecutive grant cycles per owner (timeout build only), ≥2

- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — reset, asynchronous, active-low
- `req` input N — request per requester, level-sensitive
- `din` input N*W — requester data; slice i is `din[i*W +: W]`
- `grant` output N — registered one-hot-or-zero grant
- `bus_out` output W — OR over i of (`din` slice i AND replicated `grant[i]`), combinational from `grant`
- `bus_valid` output 1 — OR-reduction of `grant`
- `owner` output clog2(N) — index of the current or last owner, registered

## Operation
- States:
  - IDLE: `grant` is 0.
  - OWN: exactly one `grant` bit is 1.
- Round-robin pointer `ptr` is the search start index. `ptr` = `owner` + 1 mod N, updated whenever a grant ends.
- Arbitration happens at an edge when any of these holds:
  - the state is IDLE;
  - the owner's `req` is low;
  - (timeout build) the hold limit is reached.
- Winner selection: the first i with `req[i]` = 1, searching `ptr`, `ptr`+1, … with wrap-around mod N.
- IDLE → OWN: when any `req` is 1. Set `grant[winner]` and `owner` = winner.
- OWN, owner `req` still 1, no timeout: hold. `grant` is unchanged and no other requester is considered.
- OWN, owner `req` drops:
  - If another request is pending, hand off at the same edge to the next winner. There is no idle bubble.
  - Otherwise go to IDLE.
- Timeout handoff: the owner is excluded from that one arbitration.
  - If another request is pending, it wins.
  - If no other request is pending, go to IDLE for one cycle. The old owner can win again at the next edge.
- Simultaneous requests: rotation order from `ptr` decides. Fairness: a continuously asserted request is granted within N−1 handoffs.
- `bus_out` is 0 whenever `grant` is 0. Data is never latched; it passes through combinationally.
- Reset mid-operation drops `grant` immediately, without waiting for a clock edge.

## Timing
- Reset values:
  - `grant` = 0, `owner` = 0, `ptr` = 0, hold counter = 0, state IDLE.
  - Derived outputs: `bus_valid` = 0, `bus_out` = 0.
- Latency:
  - `req` sampled high at edge k → `grant` high after edge k, so `bus_out` is valid in cycle k+1.
  - Release: owner `req` sampled low at edge k → owner `grant` is low after edge k.
- Hold counter `hcnt`, width clog2(MAX_HOLD):
  - Cleared on every new grant.
  - Increments each edge while OWN holds.
  - An edge that sees `hcnt` = MAX_HOLD−1 forces arbitration, so one owner keeps the grant for at most MAX_HOLD cycles.
- `req` deasserting and timeout at the same edge are treated as a release: the owner is not excluded because its `req` is already low.
- `req` is sampled only at clock edges. Glitches between edges have no effect.

## Configuration
- `OR_BUS_ARB_TIMEOUT_EN` defined:
  - `hcnt` and the forced-release logic are compiled in.
  - The owner is limited to MAX_HOLD consecutive cycles.
- Not defined:
  - No counter is built and `MAX_HOLD` is ignored.
  - An owner holds until its `req` drops, which can be indefinite.

## Structure
- Package `or_bus_arb_pkg`:
  - state enum (IDLE, OWN);
  - default `N`/`W`/`MAX_HOLD` constants;
  - an index-width helper constant expression.
- Sub-module `rr_pick`: purely combinational rotating-priority picker.
  - Inputs: `req` vector, `ptr`, exclude mask.
  - Outputs: winner index, `found` flag.
- The top level holds the state register, `grant`/`owner`/`ptr` registers, `hcnt` (under the macro) and the AND-OR bus mux.

## Test plan
1. Reset, then `req` = 4'b0100 with `din` slice 2 = 8'hA5 held high:
   - `grant` = 4'b0100 one cycle later;
   - `bus_out` = 8'hA5, `bus_valid` = 1;
   - other slices = 8'hFF do not leak onto `bus_out`.
2. `req` = 4'b1111 from reset, each requester dropping its `req` 3 cycles after its own grant: grant order is 0, 1, 2, 3, 0, with no idle cycle between owners.
3. Owner 1 drops `req`, then `req` = 4'b0011 at the next edge: requester 0 is granted next, not requester 1, because `ptr` = 2 wraps to 0 before reaching 1.
4. Timeout build, `MAX_HOLD` = 4:
   - `req` = 4'b0001 held forever: `grant[0]` high for exactly 4 cycles, then 1 IDLE cycle, then re-granted.
   - With `req` = 4'b1001 held: handoff to 3 after 4 cycles.
5. `rst_n` pulsed low mid-grant, asynchronously between edges: `grant`, `bus_valid` and `bus_out` go to 0 immediately, and arbitration restarts from `ptr` = 0.
6. Non-timeout build, `req` = 4'b0011 held for 100 cycles: `grant` stays 4'b0001 throughout.

Source files
------------

// File: rtl/or_bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// or_bus_arb_pkg
// Shared definitions for the OR-combined bus arbiter:
//   - arb_state_e : arbiter state (IDLE / OWN)
//   - N_DEF, W_DEF, MAX_HOLD_DEF : default parameter values
//   - idx_w()     : index width helper, clog2 with a floor of 1 bit
// Optional feature macro used by the arbiter: OR_BUS_ARB_TIMEOUT_EN
// ---------------------------------------------------------------------------
package or_bus_arb_pkg;

  localparam int N_DEF        = 4;
  localparam int W_DEF        = 8;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Width needed to index n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/or_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational rotating-priority picker.
// Ports:
//   req_i   [N-1:0]  request vector
//   ptr_i   [IW-1:0] search start index (0..N-1)
//   excl_i  [N-1:0]  requesters excluded from this search
//   win_o   [IW-1:0] first eligible index found from ptr_i with wrap-around
//   found_o          at least one eligible requester exists
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  excl_i,
  output logic [IW-1:0] win_o,
  output logic          found_o
);

  logic [N-1:0] cand_s;
  logic [IW:0]  idx_s;

  assign cand_s = req_i & ~excl_i;

  // Walk ptr, ptr+1, ... (mod N) and keep the first eligible requester.
  // One extra bit on idx_s holds ptr+offset before the wrap subtraction,
  // which avoids a modulo for non-power-of-two N.
  always_comb begin
    win_o   = '0;
    found_o = 1'b0;
    idx_s   = '0;
    for (int off = 0; off < N; off++) begin
      idx_s = {1'b0, ptr_i} + (IW + 1)'(off);
      if (idx_s >= (IW + 1)'(N)) begin
        idx_s = idx_s - (IW + 1)'(N);
      end else begin
        idx_s = idx_s;
      end
      if (!found_o && cand_s[idx_s[IW-1:0]]) begin
        found_o = 1'b1;
        win_o   = idx_s[IW-1:0];
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/or_bus_arbiter.sv
// ---------------------------------------------------------------------------
// or_bus_arbiter
// Round-robin arbiter sharing one W-bit AND-OR bus among N requesters.
// Only the granted slice of din reaches bus_out.
// Optional feature: define OR_BUS_ARB_TIMEOUT_EN to limit an owner to
// MAX_HOLD consecutive grant cycles (otherwise MAX_HOLD is ignored).
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req  [N]   level-sensitive request per requester
//   din  [N*W] requester data, slice i = din[i*W +: W]
//   grant[N]   registered one-hot-or-zero grant
//   bus_out[W] AND-OR of din slices with grant (combinational from grant)
//   bus_valid  OR-reduction of grant
//   owner      index of the current or last owner (registered)
// ---------------------------------------------------------------------------
module or_bus_arbiter
  import or_bus_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int W        = W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N*W-1:0]        din,
  output logic [N-1:0]          grant,
  output logic [W-1:0]          bus_out,
  output logic                  bus_valid,
  output logic [idx_w(N)-1:0]   owner
);

  localparam int IW = idx_w(N);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [IW-1:0] owner_inc_s;
  logic [IW-1:0] start_s;
  logic [N-1:0]  excl_s;
  logic [IW-1:0] win_s;
  logic          found_s;
  logic          owner_req_s;
  logic          timeout_s;
  logic          arb_s;

  assign owner_inc_s = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
  assign owner_req_s = req[owner_q];

  // While owning, the grant is about to end, so the search starts where the
  // pointer will land (owner + 1); from IDLE it starts at the stored pointer.
  assign start_s = (state_q == ST_OWN) ? owner_inc_s : ptr_q;

  assign arb_s = (state_q == ST_IDLE) || !owner_req_s || timeout_s;

`ifdef OR_BUS_ARB_TIMEOUT_EN
  localparam int HW = idx_w(MAX_HOLD);

  logic [HW-1:0] hcnt_q, hcnt_d;

  assign timeout_s = (state_q == ST_OWN) && (hcnt_q == HW'(MAX_HOLD - 1));

  // Hold counter next value: cleared on any arbitration, counts while holding.
  always_comb begin
    if (arb_s) begin
      hcnt_d = '0;
    end else if (state_q == ST_OWN) begin
      hcnt_d = hcnt_q + HW'(1);
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end
`else
  logic hold_unused_s;

  assign timeout_s     = 1'b0;
  assign hold_unused_s = (MAX_HOLD > 1);
`endif

  // A timed-out owner sits out exactly one arbitration. If its req is
  // already low the mask changes nothing, so a simultaneous release and
  // timeout behaves as a plain release.
  always_comb begin
    excl_s = '0;
    if (timeout_s) begin
      excl_s[owner_q] = 1'b1;
    end else begin
      excl_s = '0;
    end
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (start_s),
    .excl_i  (excl_s),
    .win_o   (win_s),
    .found_o (found_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_OWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (arb_s && !found_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OWN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grant / owner / pointer next values.
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (arb_s) begin
      if (state_q == ST_OWN) begin
        ptr_d = owner_inc_s;
      end else begin
        ptr_d = ptr_q;
      end
      grant_d = '0;
      if (found_s) begin
        grant_d[win_s] = 1'b1;
        owner_d        = win_s;
      end else begin
        owner_d = owner_q;
      end
    end else begin
      grant_d = grant_q;
    end
  end

  // Grant, owner and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // AND-OR bus: each slice masked by its grant bit, then OR-reduced.
  always_comb begin
    bus_out = '0;
    for (int i = 0; i < N; i++) begin
      bus_out = bus_out | (din[i*W +: W] & {W{grant_q[i]}});
    end
  end

  assign grant     = grant_q;
  assign bus_valid = |grant_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_or_bus_arbiter.sv
module tb_or_bus_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXH = 4;
`ifdef OR_BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   grant;
  logic [W-1:0]   bus_out;
  logic           bus_valid;
  logic [1:0]     owner;

  int checks = 0;
  int errors = 0;

  or_bus_arbiter #(.N(N), .W(W), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .grant     (grant),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // own = -1 means nobody holds the bus; hold counts cycles granted so far.
  typedef struct {
    int own;
    int last;
    int ptr;
    int hold;
  } mstate_t;

  mstate_t m = '{own: -1, last: 0, ptr: 0, hold: 0};

  function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (start + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic mstate_t model_next(input mstate_t c, input logic [N-1:0] r);
    mstate_t n;
    int w;
    bit to;
    n = c;
    if (c.own < 0) begin
      w = pick(r, c.ptr, -1);
      if (w >= 0) begin
        n.own = w; n.last = w; n.hold = 1;
      end
    end else begin
      to = TO_EN && (c.hold >= MAXH);
      if (r[c.own] && !to) begin
        n.hold = c.hold + 1;
      end else begin
        n.ptr = (c.own + 1) % N;
        w = pick(r, n.ptr, (to && r[c.own]) ? c.own : -1);
        if (w >= 0) begin
          n.own = w; n.last = w; n.hold = 1;
        end else begin
          n.own = -1; n.hold = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [N-1:0] exp_grant(input int own);
    logic [N-1:0] g;
    g = '0;
    if (own >= 0) g[own] = 1'b1;
    return g;
  endfunction

  function automatic logic [W-1:0] exp_bus(input int own, input logic [N*W-1:0] d);
    if (own < 0) return '0;
    return d[own*W +: W];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{own: -1, last: 0, ptr: 0, hold: 0};
    else        m <= model_next(m, req);
  end

  // Compare process: every falling edge, DUT against the model.
  always @(negedge clk) begin
    chk("grant", 64'(grant), 64'(exp_grant(m.own)));
    chk("owner", 64'(owner), 64'(m.last));
    chk("bus_valid", 64'(bus_valid), 64'(m.own >= 0));
    chk("bus_out", 64'(bus_out), 64'(exp_bus(m.own, din)));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int dec(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  int seq [5];
  int nseq, prev, cnt, restore, cur, idle_gap, bad;
  logic [N-1:0] exp_t4a [6];
  logic [N-1:0] exp_t4b [5];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    din   = {8'hFF, 8'hA5, 8'hFF, 8'hFF};
    tick();
    tick();
    // reset values
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_valid", 64'(bus_valid), 64'(0));
    chk("rst_bus", 64'(bus_out), 64'(0));
    rst_n = 1'b1;

    // 1: single requester 2, neighbours hold FF
    req = 4'b0100;
    tick();
    chk("t1_grant", 64'(grant), 64'(4'b0100));
    chk("t1_bus", 64'(bus_out), 64'(8'hA5));
    chk("t1_valid", 64'(bus_valid), 64'(1));
    chk("t1_owner", 64'(owner), 64'(2));
    req = 4'b0000;
    tick();
    chk("t1_release", 64'(grant), 64'(0));

    // 2: all request, each drops for one cycle after 3 granted cycles
    do_reset();
    req = 4'b1111;
    nseq = 0; prev = -1; cnt = 0; restore = -1; idle_gap = 0;
    for (int i = 0; i < 5; i++) seq[i] = -1;
    for (int c = 0; c < 40 && nseq < 5; c++) begin
      tick();
      cur = dec(grant);
      if (restore >= 0) begin
        req[restore] = 1'b1;
        restore = -1;
      end
      if (cur < 0) begin
        if (nseq > 0) idle_gap++;
      end else if (cur != prev) begin
        seq[nseq] = cur; nseq++; cnt = 1; prev = cur;
      end else begin
        cnt++;
      end
      if (cur >= 0 && cnt == 3 && nseq < 5) begin
        req[cur] = 1'b0;
        restore = cur;
      end
    end
    chk("t2_count", 64'(nseq), 64'(5));
    chk("t2_seq0", 64'(seq[0]), 64'(0));
    chk("t2_seq1", 64'(seq[1]), 64'(1));
    chk("t2_seq2", 64'(seq[2]), 64'(2));
    chk("t2_seq3", 64'(seq[3]), 64'(3));
    chk("t2_seq4", 64'(seq[4]), 64'(0));
    chk("t2_gap", 64'(idle_gap), 64'(0));

    // 3: pointer wraps past 3 to 0 before reaching 1
    do_reset();
    req = 4'b0010;
    tick();
    chk("t3_own1", 64'(grant), 64'(4'b0010));
    req = 4'b0000;
    tick();
    chk("t3_idle", 64'(grant), 64'(0));
    req = 4'b0011;
    tick();
    chk("t3_wrap", 64'(grant), 64'(4'b0001));
    chk("t3_owner", 64'(owner), 64'(0));

`ifdef OR_BUS_ARB_TIMEOUT_EN
    // 4: hold limit of 4 cycles
    exp_t4a[0] = 4'b0001; exp_t4a[1] = 4'b0001; exp_t4a[2] = 4'b0001;
    exp_t4a[3] = 4'b0001; exp_t4a[4] = 4'b0000; exp_t4a[5] = 4'b0001;
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("t4a_c%0d", c), 64'(grant), 64'(exp_t4a[c]));
    end
    exp_t4b[0] = 4'b0001; exp_t4b[1] = 4'b0001; exp_t4b[2] = 4'b0001;
    exp_t4b[3] = 4'b0001; exp_t4b[4] = 4'b1000;
    do_reset();
    req = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t4b_c%0d", c), 64'(grant), 64'(exp_t4b[c]));
    end
`else
    // 6: without the limit the owner keeps the bus indefinitely
    do_reset();
    req = 4'b0011;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (grant !== 4'b0001) bad++;
    end
    chk("t6_hold_bad_cycles", 64'(bad), 64'(0));
`endif

    // 5: asynchronous reset mid-grant, pointer restarts at 0
    do_reset();
    din = '1;
    req = 4'b0010;
    tick();
    req = 4'b0100;
    tick();
    chk("t5_pre", 64'(grant), 64'(4'b0100));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_grant", 64'(grant), 64'(0));
    chk("t5_async_valid", 64'(bus_valid), 64'(0));
    chk("t5_async_bus", 64'(bus_out), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    chk("t5_restart", 64'(grant), 64'(4'b0001));
    chk("t5_owner", 64'(owner), 64'(0));

    // random traffic against the model, with occasional async resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) req[i] = ~req[i];
      end
      for (int i = 0; i < N; i++) din[i*W +: W] = W'($urandom);
      if (c % 700 == 350) begin
        #2;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
